// File: rtl/sync_fifo_prog.sv
// ---------------------------------------------------------------------------
// sync_fifo_prog
//   Single-clock FIFO with registered occupancy level, programmable
//   almost-full / almost-empty thresholds and sticky overflow / underflow
//   error flags.
//
//   Configuration macro: SYNC_FIFO_FWFT_EN
//     undefined (default) : registered read. An accepted read loads data_read
//                           on the following edge, and data_valid pulses for
//                           that one cycle.
//     defined             : first-word-fall-through. data_read shows the head
//                           word whenever the FIFO is non-empty, data_valid is
//                           !rempty, and read_enable pops the displayed word.
//
//   Parameters
//     DEPTH       entry count, power of two, >= 4
//     DATA_WIDTH  word width
//     PTR_WIDTH   address width; level/thresholds are PTR_WIDTH+1 bits
//
//   Ports
//     clk                 rising-edge clock
//     rst                 synchronous active-high reset
//     write_enable        write request, data_write is the word
//     read_enable         read request
//     almost_full_thresh  almost_full  = (level >= almost_full_thresh)
//     almost_empty_thresh almost_empty = (level <= almost_empty_thresh)
//     clear_err           clears overflow / underflow
//     data_read           read data
//     data_valid          data_read holds a popped word
//     level               occupancy 0..DEPTH
//     wfull, rempty, half_full, almost_full, almost_empty  status flags
//     overflow, underflow sticky error flags
// ---------------------------------------------------------------------------
module sync_fifo_prog #(
    parameter int DEPTH      = 512,
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] data_write,
    input  logic                  read_enable,
    input  logic [PTR_WIDTH:0]    almost_full_thresh,
    input  logic [PTR_WIDTH:0]    almost_empty_thresh,
    input  logic                  clear_err,
    output logic [DATA_WIDTH-1:0] data_read,
    output logic                  data_valid,
    output logic [PTR_WIDTH:0]    level,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  half_full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [PTR_WIDTH:0] FULL_LEVEL = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] HALF_LEVEL = (PTR_WIDTH+1)'(DEPTH / 2);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // One extra MSB on each pointer so they wrap modulo 2*DEPTH.
    logic [PTR_WIDTH:0] wptr;
    logic [PTR_WIDTH:0] rptr;

    logic wr_acc;
    logic rd_acc;

    // Flags decode straight from the registered level, no extra delay.
    always_comb begin
        wfull        = (level == FULL_LEVEL);
        rempty       = (level == '0);
        half_full    = (level >= HALF_LEVEL);
        almost_full  = (level >= almost_full_thresh);
        almost_empty = (level <= almost_empty_thresh);
    end

    // A full FIFO still accepts a read and an empty one still accepts a
    // write, so the simultaneous-request cases fall out of these terms.
    always_comb begin
        wr_acc = write_enable && !wfull;
        rd_acc = read_enable  && !rempty;
    end

    // Storage is not reset; a write in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wptr[PTR_WIDTH-1:0]] <= data_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sticky errors: a new error in the same cycle as clear_err wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_enable && wfull) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end
            if (read_enable && rempty) begin
                underflow <= 1'b1;
            end else if (clear_err) begin
                underflow <= 1'b0;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is always on display; the zero while empty keeps the
    // output defined straight out of reset.
    always_comb begin
        data_read  = rempty ? '0 : mem[rptr[PTR_WIDTH-1:0]];
        data_valid = !rempty;
    end
`else
    // Registered read: data_read holds its value between accepted reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_read  <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_acc;
            if (rd_acc) begin
                data_read <= mem[rptr[PTR_WIDTH-1:0]];
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_prog
//   Directed bench for sync_fifo_prog at DEPTH=8, DATA_WIDTH=8, registered
//   read mode. Each scenario task drives its stimulus and compares outputs
//   against hand-computed values one time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_sync_fifo_prog;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int PW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          write_enable;
    logic [DW-1:0] data_write;
    logic          read_enable;
    logic [PW:0]   almost_full_thresh;
    logic [PW:0]   almost_empty_thresh;
    logic          clear_err;
    logic [DW-1:0] data_read;
    logic          data_valid;
    logic [PW:0]   level;
    logic          wfull, rempty, half_full, almost_full, almost_empty;
    logic          overflow, underflow;

    int checks = 0;
    int errors = 0;

    sync_fifo_prog #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW),
        .PTR_WIDTH  (PW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .write_enable        (write_enable),
        .data_write          (data_write),
        .read_enable         (read_enable),
        .almost_full_thresh  (almost_full_thresh),
        .almost_empty_thresh (almost_empty_thresh),
        .clear_err           (clear_err),
        .data_read           (data_read),
        .data_valid          (data_valid),
        .level               (level),
        .wfull               (wfull),
        .rempty              (rempty),
        .half_full           (half_full),
        .almost_full         (almost_full),
        .almost_empty        (almost_empty),
        .overflow            (overflow),
        .underflow           (underflow)
    );

    always #5 clk = ~clk;

    // Apply one cycle of requests, then release them and settle past the edge.
    task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re);
        write_enable = we;
        data_write   = wd;
        read_enable  = re;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        clear_err    = 1'b0;
        rst          = 1'b0;
    endtask

    task automatic test_reset();
        almost_full_thresh  = 4'd0;
        almost_empty_thresh = 4'd2;
        rst       = 1'b1;
        clear_err = 1'b0;
        cycle(1'b1, 8'hEE, 1'b1);
        rst = 1'b1;
        cycle(1'b1, 8'hEE, 1'b1);
        checks++; if (level !== 4'd0)      begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (rempty !== 1'b1)     begin errors++; $display("FAIL reset_rempty got %b exp 1", rempty); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty got %b exp 1", almost_empty); end
        checks++; if (wfull !== 1'b0)      begin errors++; $display("FAIL reset_wfull got %b exp 0", wfull); end
        checks++; if (half_full !== 1'b0)  begin errors++; $display("FAIL reset_half_full got %b exp 0", half_full); end
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL reset_almost_full_thr0 got %b exp 1", almost_full); end
        checks++; if (data_read !== 8'h00) begin errors++; $display("FAIL reset_data_read got %0h exp 0", data_read); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid got %b exp 0", data_valid); end
        checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        checks++; if (underflow !== 1'b0)  begin errors++; $display("FAIL reset_underflow got %b exp 0", underflow); end
        // Write presented during reset must have been dropped.
        cycle(1'b0, 8'h00, 1'b0);
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_write_discard level got %0d exp 0", level); end
        almost_full_thresh = 4'd6;
        #1;
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL almost_full_thr6_empty got %b exp 0", almost_full); end
    endtask

    // Fill 0x01..0x08, then one write too many.
    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, DW'(i), 1'b0);
            checks++; if (level !== 4'(i)) begin errors++; $display("FAIL fill_level[%0d] got %0d exp %0d", i, level, i); end
            checks++; if (half_full !== (i >= 4)) begin errors++; $display("FAIL fill_half_full[%0d] got %b exp %b", i, half_full, (i >= 4)); end
            checks++; if (wfull !== (i == 8)) begin errors++; $display("FAIL fill_wfull[%0d] got %b exp %b", i, wfull, (i == 8)); end
            checks++; if (almost_full !== (i >= 6)) begin errors++; $display("FAIL fill_almost_full[%0d] got %b exp %b", i, almost_full, (i >= 6)); end
            checks++; if (almost_empty !== (i <= 2)) begin errors++; $display("FAIL fill_almost_empty[%0d] got %b exp %b", i, almost_empty, (i <= 2)); end
            checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL fill_rempty[%0d] got %b exp 0", i, rempty); end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_no_overflow got %b exp 0", overflow); end
        cycle(1'b1, 8'hFF, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got %b exp 1", overflow); end
        checks++; if (level !== 4'd8)    begin errors++; $display("FAIL overflow_level got %0d exp 8", level); end
    endtask

    // Drain in order, then one read too many; then clear both sticky flags.
    task automatic test_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            checks++; if (data_read !== DW'(i)) begin errors++; $display("FAIL drain_data[%0d] got %0h exp %0h", i, data_read, i); end
            checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got %b exp 1", i, data_valid); end
            checks++; if (level !== 4'(DEPTH - i)) begin errors++; $display("FAIL drain_level[%0d] got %0d exp %0d", i, level, DEPTH - i); end
        end
        checks++; if (rempty !== 1'b1)   begin errors++; $display("FAIL drain_rempty got %b exp 1", rempty); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b exp 1", overflow); end
        cycle(1'b0, 8'h00, 1'b0);
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL valid_one_cycle got %b exp 0", data_valid); end
        checks++; if (data_read !== 8'h08) begin errors++; $display("FAIL data_hold got %0h exp 08", data_read); end
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (underflow !== 1'b1)  begin errors++; $display("FAIL underflow_set got %b exp 1", underflow); end
        checks++; if (level !== 4'd0)      begin errors++; $display("FAIL underflow_level got %0d exp 0", level); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL underflow_valid got %b exp 0", data_valid); end
        clear_err = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL clear_overflow got %b exp 0", overflow); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL clear_underflow got %b exp 0", underflow); end
    endtask

    // Simultaneous read+write at full and at empty; set beats clear.
    task automatic test_simultaneous();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(8'h10 + i), 1'b0);
        cycle(1'b1, 8'h99, 1'b1);
        checks++; if (level !== 4'd7)      begin errors++; $display("FAIL full_rw_level got %0d exp 7", level); end
        checks++; if (overflow !== 1'b1)   begin errors++; $display("FAIL full_rw_overflow got %b exp 1", overflow); end
        checks++; if (data_read !== 8'h10) begin errors++; $display("FAIL full_rw_data got %0h exp 10", data_read); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL full_rw_valid got %b exp 1", data_valid); end
        for (int i = 1; i < DEPTH; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            checks++; if (data_read !== DW'(8'h10 + i)) begin errors++; $display("FAIL full_rw_drain[%0d] got %0h exp %0h", i, data_read, 8'h10 + i); end
        end
        clear_err = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h55, 1'b1);
        checks++; if (level !== 4'd1)      begin errors++; $display("FAIL empty_rw_level got %0d exp 1", level); end
        checks++; if (underflow !== 1'b1)  begin errors++; $display("FAIL empty_rw_underflow got %b exp 1", underflow); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL empty_rw_valid got %b exp 0", data_valid); end
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (data_read !== 8'h55) begin errors++; $display("FAIL empty_rw_data got %0h exp 55", data_read); end
        clear_err = 1'b1;
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL set_beats_clear got %b exp 1", underflow); end
        clear_err = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL clear_after_set got %b exp 0", underflow); end
    endtask

    // 20 write/read pairs carry both pointers across the wrap.
    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, DW'(8'h30 + i), 1'b0);
            cycle(1'b0, 8'h00, 1'b1);
            checks++; if (data_read !== DW'(8'h30 + i)) begin errors++; $display("FAIL wrap_data[%0d] got %0h exp %0h", i, data_read, 8'h30 + i); end
        end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL wrap_level got %0d exp 0", level); end
    endtask

    // Reset at level 5 with a pending write, then a fresh word round-trips.
    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(8'hC0 + i), 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'hC7, 1'b0);
        cycle(1'b1, 8'h77, 1'b0);
        checks++; if (level !== 4'd6)      begin errors++; $display("FAIL pre_reset_level got %0d exp 6", level); end
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (level !== 4'd5)      begin errors++; $display("FAIL pre_reset_level5 got %0d exp 5", level); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b exp 1", data_valid); end
        rst = 1'b1;
        cycle(1'b1, 8'hBB, 1'b1);
        checks++; if (level !== 4'd0)      begin errors++; $display("FAIL mid_reset_level got %0d exp 0", level); end
        checks++; if (rempty !== 1'b1)     begin errors++; $display("FAIL mid_reset_rempty got %b exp 1", rempty); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL mid_reset_almost_empty got %b exp 1", almost_empty); end
        checks++; if (wfull !== 1'b0)      begin errors++; $display("FAIL mid_reset_wfull got %b exp 0", wfull); end
        checks++; if (half_full !== 1'b0)  begin errors++; $display("FAIL mid_reset_half_full got %b exp 0", half_full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL mid_reset_almost_full got %b exp 0", almost_full); end
        checks++; if (data_read !== 8'h00) begin errors++; $display("FAIL mid_reset_data_read got %0h exp 0", data_read); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_data_valid got %b exp 0", data_valid); end
        checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL mid_reset_overflow got %b exp 0", overflow); end
        checks++; if (underflow !== 1'b0)  begin errors++; $display("FAIL mid_reset_underflow got %b exp 0", underflow); end
        cycle(1'b1, 8'hAA, 1'b0);
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL post_reset_level got %0d exp 1", level); end
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (data_read !== 8'hAA) begin errors++; $display("FAIL post_reset_data got %0h exp AA", data_read); end
        checks++; if (rempty !== 1'b1)     begin errors++; $display("FAIL post_reset_rempty got %b exp 1", rempty); end
    endtask

    initial begin
        rst                 = 1'b1;
        write_enable        = 1'b0;
        data_write          = '0;
        read_enable         = 1'b0;
        clear_err           = 1'b0;
        almost_full_thresh  = 4'd0;
        almost_empty_thresh = 4'd2;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
